// File: rtl/any1_wb_ram_slave.sv
// Wishbone classic-cycle RAM slave with a decoded address window, programmable wait states,
// byte-lane writes, error termination for misses and cycle abort on cyc_i drop.
module any1_wb_ram_slave #(
  parameter int             DW          = 128,
  parameter int             DEPTH       = 1024,
  parameter int             AW          = 32,
  parameter logic [AW-1:0]  BASE        = '0,
  parameter int             WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [DW/8-1:0]   sel_i,
  input  logic [AW-1:0]     adr_i,
  input  logic [DW-1:0]     dat_i,
  output logic              ack_o,
  output logic              err_o,
  output logic [DW-1:0]     dat_o
);

  localparam int SW  = DW / 8;
  localparam int OFS = $clog2(SW);
  localparam int IDX = $clog2(DEPTH);
  localparam logic [3:0] WS_M1 = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             we_q;
  logic [SW-1:0]    sel_q;
  logic [IDX-1:0]   idx_q;
  logic [DW-1:0]    dat_q;
  logic             hit_q;
  logic [DW-1:0]    mem [DEPTH];
  logic             hit;
  logic             req;
  logic             commit_wr;
  logic             unused_low_bits;

  assign hit             = (adr_i[AW-1:OFS+IDX] == BASE[AW-1:OFS+IDX]);
  assign req             = cyc_i && stb_i;
  assign unused_low_bits = ^adr_i[OFS-1:0];
  // A write lands only on a live, in-window response; reset or abort in RESP discards it.
  assign commit_wr       = (state == S_RESP) && cyc_i && hit_q && we_q && rst_i;

  // Request capture: later bus changes are ignored until the slave returns to idle.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && req) begin
      we_q  <= we_i;
      sel_q <= sel_i;
      idx_q <= adr_i[OFS+IDX-1:OFS];
      dat_q <= dat_i;
      hit_q <= hit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit_wr) begin
      for (int b = 0; b < SW; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            cnt   <= WS_M1;
            state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!cyc_i)          state <= S_IDLE;
          else if (cnt == '0)  state <= S_RESP;
          else                 cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          if (!cyc_i) begin
            state <= S_IDLE;
          end else begin
            state <= S_GAP;
            if (hit_q) begin
              ack_o <= 1'b1;
              if (!we_q) dat_o <= mem[idx_q];
            end else begin
              err_o <= 1'b1;
              dat_o <= '0;
            end
          end
        end
        // One dead cycle so the master always sees ack/err fall between requests.
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_any1_wb_ram_slave.sv
// Bench for any1_wb_ram_slave: a zero-wait and a three-wait instance driven by directed
// and random Wishbone transactions, checked against a byte-level memory model.
module tb_any1_wb_ram_slave;

  localparam int WIN = 1024 * 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cyc   [2];
  logic         stb   [2];
  logic         we    [2];
  logic [15:0]  sel   [2];
  logic [31:0]  adr   [2];
  logic [127:0] dat_w [2];
  logic         ack   [2];
  logic         err   [2];
  logic [127:0] dat_r [2];

  logic [127:0] mref  [2][1024];
  logic [15:0]  mval  [2][1024];
  bit           kept  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  any1_wb_ram_slave #(.DW(128), .DEPTH(1024), .AW(32), .BASE(32'h0), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .sel_i(sel[0]),
    .adr_i(adr[0]), .dat_i(dat_w[0]), .ack_o(ack[0]), .err_o(err[0]), .dat_o(dat_r[0]));

  any1_wb_ram_slave #(.DW(128), .DEPTH(1024), .AW(32), .BASE(32'h0), .WAIT_STATES(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .sel_i(sel[1]),
    .adr_i(adr[1]), .dat_i(dat_w[1]), .ack_o(ack[1]), .err_o(err[1]), .dat_o(dat_r[1]));

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus transaction. keep=1 holds cyc/stb for an immediate back-to-back request;
  // wiggle=1 drops stb and scrambles adr/dat right after the request is captured.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [15:0] s,
                      input logic [127:0] v, input bit keep, input bit wiggle, input string tag);
    int exp_lat, cap, k, idx;
    bit hit;
    logic [127:0] mask;
    exp_lat = (kept[d] ? 3 : 2) + ws(d);
    cap     = exp_lat - 1 - ws(d);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dat_w[d] = v;
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (ack[d] || err[d]) break;
      if (wiggle && k == cap) begin
        stb[d] = 1'b0; adr[d] = $urandom; dat_w[d] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    check({tag, "_lat"}, k, exp_lat);
    hit = (a < WIN);
    check({tag, "_ack"}, ack[d], hit);
    check({tag, "_err"}, err[d], !hit);
    if (hit) begin
      idx = int'(a >> 4);
      if (w) begin
        for (int b = 0; b < 16; b++) begin
          if (s[b]) begin
            mref[d][idx][8*b +: 8] = v[8*b +: 8];
            mval[d][idx][b] = 1'b1;
          end
        end
      end else begin
        mask = '0;
        for (int b = 0; b < 16; b++) if (mval[d][idx][b]) mask[8*b +: 8] = 8'hFF;
        check({tag, "_rdata"}, dat_r[d] & mask, mref[d][idx] & mask);
      end
    end else begin
      check({tag, "_errdata"}, dat_r[d], 128'h0);
    end
    kept[d] = keep;
    if (!keep) begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
      @(posedge clk); #1;
      check({tag, "_gap"}, {ack[d], err[d]}, 2'b00);
    end
  endtask

  task automatic quiet(input int d, input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ack[0] || err[0] || ack[1] || err[1]) seen = 1'b1;
    end
    check({tag, "_noresp"}, seen, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]  a;
    logic [15:0]  s;
    logic [127:0] v;
    bit           w, keep, wig;
    for (int d = 0; d < 2; d++) begin
      kept[d] = 1'b0;
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = '0; adr[d] = '0; dat_w[d] = '0;
      for (int i = 0; i < 1024; i++) begin mval[d][i] = '0; mref[d][i] = '0; end
    end

    // Reset held with a live request: no response at all
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 16'hFFFF; adr[0] = 32'h10;
    dat_w[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_ack", ack[0], 1'b0);
      check("rst_err", err[0], 1'b0);
      check("rst_dat", dat_r[0], 128'h0);
    end
    rst = 1'b1;

    // Zero-wait write then back-to-back read (3-cycle spacing)
    xfer(0, 1'b1, 32'h10, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b1, 1'b0, "zw_wr");
    xfer(0, 1'b0, 32'h10, 16'h0000, '0, 1'b0, 1'b0, "zw_rd");
    check("zw_const", dat_r[0], 128'h0123456789ABCDEF0123456789ABCDEF);

    // Byte lanes
    xfer(0, 1'b1, 32'h20, 16'hFFFF, {128{1'b1}}, 1'b0, 1'b0, "bl_pre");
    xfer(0, 1'b1, 32'h20, 16'h00F0, 128'h0, 1'b0, 1'b0, "bl_wr");
    xfer(0, 1'b0, 32'h27, 16'h0001, '0, 1'b0, 1'b0, "bl_rd");
    check("bl_const", dat_r[0], 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);

    // Wait states
    xfer(1, 1'b1, 32'h40, 16'hFFFF, 128'hCAFE, 1'b0, 1'b0, "ws_wr");
    xfer(1, 1'b0, 32'h40, 16'hFFFF, '0, 1'b0, 1'b0, "ws_rd");

    // Out of window
    xfer(0, 1'b1, 32'h0, 16'hFFFF, 128'h5A5A, 1'b0, 1'b0, "oow_pre");
    xfer(0, 1'b1, 32'h4000, 16'hFFFF, 128'hDEAD, 1'b0, 1'b0, "oow_wr");
    xfer(0, 1'b0, 32'h0, 16'hFFFF, '0, 1'b0, 1'b0, "oow_rd");

    // Abort by dropping cyc during wait states
    xfer(1, 1'b1, 32'h30, 16'hFFFF, 128'hAAAA_0000_1111, 1'b0, 1'b0, "ab_pre");
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 16'hFFFF; adr[1] = 32'h30; dat_w[1] = 128'hBAD;
    @(posedge clk); @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    quiet(1, 6, "ab_cyc");
    xfer(1, 1'b0, 32'h30, 16'hFFFF, '0, 1'b0, 1'b0, "ab_rd");

    // Abort by reset during wait states
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 16'hFFFF; adr[1] = 32'h30; dat_w[1] = 128'hBAD2;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    check("ar_dat", dat_r[1], 128'h0);
    quiet(1, 6, "ar_rst");
    xfer(1, 1'b0, 32'h30, 16'hFFFF, '0, 1'b0, 1'b0, "ar_rd");

    // Abort in the response cycle of the zero-wait slave
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 16'hFFFF; adr[0] = 32'h10; dat_w[0] = 128'hBAD3;
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    quiet(0, 4, "ab_resp");
    xfer(0, 1'b0, 32'h10, 16'hFFFF, '0, 1'b0, 1'b0, "ab_resp_rd");

    // Random traffic
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        a = 32'($urandom_range(0, 15)) * 32'd16 + 32'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) a = a + 32'h4000 * 32'($urandom_range(1, 1000));
        w    = 1'($urandom_range(0, 1));
        s    = 16'($urandom);
        v    = {$urandom, $urandom, $urandom, $urandom};
        keep = (i != 39) && ($urandom_range(0, 2) == 0);
        wig  = ($urandom_range(0, 3) == 0);
        xfer(d, w, a, s, v, keep, wig, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
